pixel_merge_buffer: RTL
=======================

PIXEL_MERGE_BUFFER -- requirements
Module: pixel_merge_buffer

Interface
REQ-001 SHALL have parameter NUM_CORES, default 4: number of compute-core pixel ports (1..8).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8: per-core FIFO entries (power of 2, 2..32).
REQ-003 SHALL have parameter DIM_W, default 13: width of the image dimension inputs.
REQ-004 aclk  in  1  the only clock; all logic on its rising edge.
REQ-005 aresetn  in  1  reset, asynchronous assert, active-low.
REQ-006 start  in  1  one-cycle pulse that begins a frame.
REQ-007 extra_cores  in  3  active cores minus one.
REQ-008 image_width, image_height  in  DIM_W each  frame size in pixels.
REQ-009 r_in, g_in, b_in  in  8*NUM_CORES each  per-core colour, core k in bits [8k+7:8k].
REQ-010 valid_in  in  NUM_CORES  per-core pixel valid.
REQ-011 compute_ready  out  NUM_CORES  per-core accept; a transfer occurs when valid_in[k] && compute_ready[k].
REQ-012 in_stream_ready  in  1  downstream ready.
REQ-013 out_r, out_g, out_b  out  8 each  output pixel.
REQ-014 out_valid, out_sof, out_last_x  out  1 each  stream valid, first pixel of frame, last pixel of row.
REQ-015 busy  out  1  high while state is not IDLE.

Function
REQ-016 SHALL implement states IDLE, RUN, FLUSH.
REQ-017 IDLE->RUN on start when image_width!=0 and image_height!=0; start is ignored in RUN/FLUSH and when either dimension is 0.
REQ-018 On IDLE->RUN, extra_cores, image_width and image_height SHALL be latched; active count A=min(extra_cores+1, NUM_CORES); later input changes are ignored until IDLE.
REQ-019 compute_ready[k] SHALL be high only in RUN, for k<A, when FIFO k is not full; valid_in[k] for k>=A or outside RUN is dropped.
REQ-020 Output pixel p (raster index, 0-based) SHALL be taken from FIFO (p mod A), in order, wrapping core index A-1->0.
REQ-021 Output register SHALL load when (!out_valid || in_stream_ready) and the selected FIFO is non-empty; out_* stay stable while out_valid && !in_stream_ready.
REQ-022 Latency: a pixel written at edge E, with its FIFO selected and output free, SHALL drive out_valid after edge E+1.
REQ-023 out_sof SHALL be high with pixel p=0; out_last_x high when column x=W-1; x wraps to 0 and y increments at row end.
REQ-024 RUN->FLUSH after W*H pixels have been loaded into the output register; FLUSH->IDLE when the final pixel is accepted downstream.
REQ-025 Simultaneous FIFO write and read on the same core SHALL both occur; a full FIFO with a simultaneous read still deasserts compute_ready that cycle.
REQ-026 Pixel counter SHALL be 2*DIM_W bits wide.

Reset
REQ-027 On aresetn low, SHALL enter IDLE immediately: FIFOs emptied, counters 0, compute_ready=0, out_valid/out_sof/out_last_x/busy=0, out_r/g/b=0.
REQ-028 Reset mid-frame SHALL discard all buffered pixels; no partial pixel is emitted after release.

Configuration
REQ-029 Macro PIXEL_MERGE_STATS_EN: when defined, SHALL add outputs frame_count (16b, increments on FLUSH->IDLE, wraps) and stall_cycles (32b, saturating; counts RUN/FLUSH cycles with out_valid && !in_stream_ready, cleared on start).
REQ-030 Without PIXEL_MERGE_STATS_EN, those ports and counters SHALL not exist.

Structure
REQ-031 Shared package pixel_pkg SHALL hold the pixel struct type (r,g,b), the state enum, and MAX_CORES=8.
REQ-032 Per-core FIFO SHALL be sub-module pixel_fifo (parametrised depth, full/empty, registered read), instantiated NUM_CORES times via generate.

Verification
REQ-033 NUM_CORES=4, extra_cores=3, W=4,H=2, cores each send 2 pixels tagged r=core -> out_r sequence 0,1,2,3,0,1,2,3; sof on first, last_x on 4th and 8th; busy falls after 8th accept.
REQ-034 extra_cores=1, W=3,H=1, valid_in[3:2] held high -> compute_ready[3:2]=0; out_r 0,1,0.
REQ-035 in_stream_ready low 10 cycles mid-frame -> out_* stable; FIFOs fill to FIFO_DEPTH then compute_ready drops; no loss or duplication.
REQ-036 start with W=0 -> busy stays 0, compute_ready=0.
REQ-037 aresetn pulsed after 5 of 16 pixels -> all outputs 0; new start yields fresh frame with sof on first pixel.
REQ-038 With PIXEL_MERGE_STATS_EN, two frames and 7 stall cycles in the second -> frame_count=2, stall_cycles=7.

Source files
------------

// File: rtl/pixel_pkg.sv
// pixel_pkg: shared types for the pixel merge buffer.
// Pixel bundle, FSM state encoding and core limit.
package pixel_pkg;

  localparam int MAX_CORES = 8;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

endpackage

// File: rtl/pixel_fifo.sv
// pixel_fifo: per-core pixel FIFO, power-of-2 depth.
// Register-array storage; head entry drives rdata_o.
module pixel_fifo
  import pixel_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   clr_i,
  input  logic   wr_en_i,
  input  pixel_t wdata_i,
  input  logic   rd_en_i,
  output pixel_t rdata_o,
  output logic   full_o,
  output logic   empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  pixel_t        mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          wr, rd;

  assign full_o  = (cnt_q == FULL_CNT);
  assign empty_o = (cnt_q == '0);
  assign wr      = wr_en_i && !full_o;
  assign rd      = rd_en_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  // Pointer and occupancy next-state; clear empties the FIFO.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (wr) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd) rd_ptr_d = rd_ptr_q + 1'b1;
      cnt_d = cnt_q + (AW+1)'(wr) - (AW+1)'(rd);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage write; contents need no reset.
  always_ff @(posedge clk_i) begin
    if (wr) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/pixel_merge_buffer.sv
// pixel_merge_buffer: merges per-core pixel streams into one raster.
// Optional PIXEL_MERGE_STATS_EN adds frame_count/stall_cycles.
module pixel_merge_buffer
  import pixel_pkg::*;
#(
  parameter int NUM_CORES  = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int DIM_W      = 13
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   start,
  input  logic [2:0]             extra_cores,
  input  logic [DIM_W-1:0]       image_width,
  input  logic [DIM_W-1:0]       image_height,
  input  logic [8*NUM_CORES-1:0] r_in,
  input  logic [8*NUM_CORES-1:0] g_in,
  input  logic [8*NUM_CORES-1:0] b_in,
  input  logic [NUM_CORES-1:0]   valid_in,
  output logic [NUM_CORES-1:0]   compute_ready,
  input  logic                   in_stream_ready,
  output logic [7:0]             out_r,
  output logic [7:0]             out_g,
  output logic [7:0]             out_b,
  output logic                   out_valid,
  output logic                   out_sof,
  output logic                   out_last_x,
  output logic                   busy
`ifdef PIXEL_MERGE_STATS_EN
  ,
  output logic [15:0]            frame_count,
  output logic [31:0]            stall_cycles
`endif
);

  localparam int PW = 2 * DIM_W;
  localparam logic [2:0] MAX_IDX = 3'(NUM_CORES - 1);

  state_e           state_q, state_d;
  logic [DIM_W-1:0] w_q, w_d, h_q, h_d;
  logic [DIM_W-1:0] x_q, x_d, y_q, y_d;
  logic [2:0]       amax_q, amax_d;
  logic [2:0]       sel_q, sel_d;
  logic [PW-1:0]    cnt_q, cnt_d;
  pixel_t           pix_q, pix_d;
  logic             ov_q, ov_d;
  logic             sof_q, sof_d;
  logic             lx_q, lx_d;

  pixel_t           fifo_dout [MAX_CORES];
  logic [MAX_CORES-1:0] fifo_full, fifo_empty;

  logic run, start_ok, load, x_last, y_last;

  assign run      = (state_q == ST_RUN);
  assign start_ok = (state_q == ST_IDLE) && start &&
                    (image_width != '0) && (image_height != '0);
  assign load     = run && (!ov_q || in_stream_ready) && !fifo_empty[sel_q];
  assign x_last   = (x_q == w_q - DIM_W'(1));
  assign y_last   = (y_q == h_q - DIM_W'(1));

  for (genvar k = 0; k < MAX_CORES; k++) begin : g_core
    if (k < NUM_CORES) begin : g_fifo
      pixel_t wdata;
      assign wdata = '{r: r_in[8*k +: 8], g: g_in[8*k +: 8], b: b_in[8*k +: 8]};
      assign compute_ready[k] = run && (3'(k) <= amax_q) && !fifo_full[k];
      pixel_fifo #(
        .DEPTH(FIFO_DEPTH)
      ) u_fifo (
        .clk_i  (aclk),
        .rst_ni (aresetn),
        .clr_i  (state_q == ST_IDLE),
        .wr_en_i(valid_in[k] && compute_ready[k]),
        .wdata_i(wdata),
        .rd_en_i(load && (sel_q == 3'(k))),
        .rdata_o(fifo_dout[k]),
        .full_o (fifo_full[k]),
        .empty_o(fifo_empty[k])
      );
    end else begin : g_tie
      assign fifo_dout[k]  = '0;
      assign fifo_full[k]  = 1'b1;
      assign fifo_empty[k] = 1'b1;
    end
  end

  // Frame FSM, raster position and output register next-state.
  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    h_d     = h_q;
    x_d     = x_q;
    y_d     = y_q;
    amax_d  = amax_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    pix_d   = pix_q;
    ov_d    = ov_q;
    sof_d   = sof_q;
    lx_d    = lx_q;
    if (start_ok) begin
      state_d = ST_RUN;
      w_d     = image_width;
      h_d     = image_height;
      amax_d  = (extra_cores > MAX_IDX) ? MAX_IDX : extra_cores;
      sel_d   = '0;
      x_d     = '0;
      y_d     = '0;
      cnt_d   = '0;
    end
    if (load) begin
      pix_d = fifo_dout[sel_q];
      ov_d  = 1'b1;
      sof_d = (cnt_q == '0);
      lx_d  = x_last;
      x_d   = x_last ? '0 : x_q + DIM_W'(1);
      y_d   = x_last ? y_q + DIM_W'(1) : y_q;
      sel_d = (sel_q == amax_q) ? '0 : sel_q + 3'd1;
      cnt_d = cnt_q + PW'(1);
      if (x_last && y_last) state_d = ST_FLUSH;
    end else if (in_stream_ready) begin
      ov_d  = 1'b0;
      sof_d = 1'b0;
      lx_d  = 1'b0;
      if (state_q == ST_FLUSH) state_d = ST_IDLE;
    end
  end

  // State registers; reset drops any frame in progress.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= ST_IDLE;
      w_q     <= '0;
      h_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      amax_q  <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
      pix_q   <= '0;
      ov_q    <= 1'b0;
      sof_q   <= 1'b0;
      lx_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      h_q     <= h_d;
      x_q     <= x_d;
      y_q     <= y_d;
      amax_q  <= amax_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      pix_q   <= pix_d;
      ov_q    <= ov_d;
      sof_q   <= sof_d;
      lx_q    <= lx_d;
    end
  end

  assign out_r      = pix_q.r;
  assign out_g      = pix_q.g;
  assign out_b      = pix_q.b;
  assign out_valid  = ov_q;
  assign out_sof    = sof_q;
  assign out_last_x = lx_q;
  assign busy       = (state_q != ST_IDLE);

`ifdef PIXEL_MERGE_STATS_EN
  logic [15:0] frame_q;
  logic [31:0] stall_q;
  logic        frame_done;

  assign frame_done = (state_q == ST_FLUSH) && ov_q && in_stream_ready;

  // Completed-frame counter and saturating downstream stall counter.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      frame_q <= '0;
      stall_q <= '0;
    end else begin
      if (frame_done) frame_q <= frame_q + 16'd1;
      if (start_ok)
        stall_q <= '0;
      else if (busy && ov_q && !in_stream_ready && (stall_q != '1))
        stall_q <= stall_q + 32'd1;
    end
  end

  assign frame_count  = frame_q;
  assign stall_cycles = stall_q;
`endif

endmodule
